mem_port_arbiter: RTL

- Shares the multicycle MIPS core's single unified instruction/data memory port between two requesters: the CPU datapath (IorD-muxed address) and a loader/DMA port.
- Sits between the DataPath/Controller pair and the memory.
- Sequences each access over a fixed memory latency and returns read data with a one-cycle done pulse; the CPU's Controller FSM stalls until done.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/arb_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, owner ids and counter width helper shared by mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  function automatic int lat_w(input int mem_lat);
    return $clog2(mem_lat + 1);
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational grant selection between the CPU and loader ports.
// MEM_ARB_ROUND_ROBIN_EN turns ties into round-robin; otherwise the CPU always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_cpu_req,
  input  logic i_dma_req,
  input  logic i_last,
  output logic o_grant_valid,
  output logic o_grant_id
);
  assign o_grant_valid = i_cpu_req | i_dma_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign o_grant_id = (i_cpu_req & i_dma_req) ? ~i_last : (i_cpu_req ? OWN_CPU : OWN_DMA);
`else
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign o_grant_id    = i_cpu_req ? OWN_CPU : OWN_DMA;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU datapath and a loader/DMA port.
// Tie-break policy is selected in arb_pick by MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_done,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_owner,
  output logic              o_busy
);
  localparam int LAT_W = lat_w(MEM_LAT);
  state_t              r_state;
  logic [LAT_W-1:0]    r_cnt;
  logic                r_last;
  logic                r_owner;
  logic                r_busy;
  logic                r_cpu_done;
  logic                r_dma_done;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                w_gnt_valid;
  logic                w_gnt_id;
  logic                w_last_beat;
  arb_pick u_pick (
    .i_cpu_req     (i_cpu_req),
    .i_dma_req     (i_dma_req),
    .i_last        (r_last),
    .o_grant_valid (w_gnt_valid),
    .o_grant_id    (w_gnt_id)
  );
  assign w_last_beat = r_cnt == LAT_W'(MEM_LAT - 1);
  // The mem_* registers double as the capture registers, so requester inputs are ignored after grant.
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= OWN_DMA;
      r_owner     <= OWN_CPU;
      r_busy      <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_cpu_done <= 1'b0;
      r_dma_done <= 1'b0;
      case (r_state)
        IDLE: if (w_gnt_valid) begin
          r_state     <= ACCESS;
          r_busy      <= 1'b1;
          r_owner     <= w_gnt_id;
          r_last      <= w_gnt_id;
          r_cnt       <= '0;
          r_mem_en    <= 1'b1;
          r_mem_we    <= w_gnt_id ? i_dma_we : i_cpu_we;
          r_mem_addr  <= w_gnt_id ? i_dma_addr : i_cpu_addr;
          r_mem_wdata <= w_gnt_id ? i_dma_wdata : i_cpu_wdata;
        end
        ACCESS: begin
          r_cnt <= r_cnt + LAT_W'(1);
          if (w_last_beat) begin
            r_state    <= DONE;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_done <= r_owner == OWN_CPU;
            r_dma_done <= r_owner == OWN_DMA;
            if (!r_mem_we && r_owner == OWN_CPU) r_cpu_rdata <= i_mem_rdata;
            if (!r_mem_we && r_owner == OWN_DMA) r_dma_rdata <= i_mem_rdata;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_done  = r_cpu_done;
  assign o_dma_rdata = r_dma_rdata;
  assign o_dma_done  = r_dma_done;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_owner     = r_owner;
  assign o_busy      = r_busy;
endmodule
